// File: rtl/bit_engine.sv
// bit_engine: W-bit operand engine running one of four bit-serial operations, one bit per clock.
// Latency: W+2 cycles from accepted start to done for modes 00/10; k+2 cycles for modes 01/11 with k steps.
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored while RUN is active.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   x, on        operand and operation select, captured on the accepted start
//   start        level-sampled start request
//   y, s, b      result register, step count (0..W), mode flag
//   active       high while in RUN
//   regime       operation latched at the accepted start
//   done         one-cycle pulse on the first cycle of DONE
//
// Build option: BIT_ENGINE_REVERSE_EN enables mode 10 (bit reverse + palindrome flag).
// Without it, mode 10 runs as popcount while regime still reports 10.
module bit_engine #(
  parameter int W = 8,
  localparam int SW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic [1:0]    on,
  input  logic          start,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b,
  output logic          active,
  output logic [1:0]    regime,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] it;
  logic [1:0]    mode;     // operation actually executed
  logic          at_end;   // all W steps taken
  logic          term;
  logic [SW-1:0] s_pc;     // popcount running sum including current LSB

`ifdef BIT_ENGINE_REVERSE_EN
  logic [W-1:0]  t;        // bits still to be fed into y, LSB first
  logic [W-1:0]  xc;       // operand copy for the palindrome check
`endif

  assign active = (state == RUN);
  assign at_end = (it == SW'(W));
  assign s_pc   = s + SW'(y[0]);

  always_comb begin
`ifdef BIT_ENGINE_REVERSE_EN
    mode = regime;
`else
    mode = (regime == 2'b10) ? 2'b00 : regime;
`endif
  end

  // Termination is evaluated before any step in a RUN cycle.
  always_comb begin
    term = at_end;
    case (mode)
      2'b01:   term = y[W-1] | at_end;
      2'b11:   term = y[0] | at_end;
      default: term = at_end;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (term)  state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y      <= '0;
      s      <= '0;
      b      <= 1'b0;
      regime <= 2'b00;
      done   <= 1'b0;
      it     <= '0;
`ifdef BIT_ENGINE_REVERSE_EN
      t      <= '0;
      xc     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != RUN) begin
        if (start) begin
          y      <= x;
          s      <= '0;
          b      <= 1'b0;
          it     <= '0;
          regime <= on;
`ifdef BIT_ENGINE_REVERSE_EN
          t      <= x;
          xc     <= x;
`endif
        end
      end else if (term) begin
        // Final cycle of RUN: no data step, only the end-of-operation flag.
        done <= 1'b1;
        case (mode)
          2'b01:   b <= ~y[W-1];   // never found a leading one: operand was zero
          2'b11:   b <= ~y[0];     // never found a trailing one: operand was zero
`ifdef BIT_ENGINE_REVERSE_EN
          2'b10:   b <= (y == xc);
`endif
          default: ;
        endcase
      end else begin
        it <= it + SW'(1);
        case (mode)
          2'b00: begin
            y <= {y[0], y[W-1:1]};
            s <= s_pc;
            b <= s_pc[0];
          end
          2'b01: begin
            y <= {y[W-2:0], 1'b0};
            s <= s + SW'(1);
          end
          2'b11: begin
            y <= {1'b0, y[W-1:1]};
            s <= s + SW'(1);
          end
`ifdef BIT_ENGINE_REVERSE_EN
          2'b10: begin
            y <= {y[W-2:0], t[0]};
            t <= {1'b0, t[W-1:1]};
            s <= s + SW'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_engine.sv
// Directed bench for bit_engine: an 8-bit instance for per-mode, reset and start-handling
// vectors, and a 13-bit instance for back-to-back runs with start held high.
module tb_bit_engine;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  x;
  logic [1:0]  on;
  logic        start;
  logic [7:0]  y;
  logic [3:0]  s;
  logic        b, active, done;
  logic [1:0]  regime;

  logic [12:0] x13;
  logic [1:0]  on13;
  logic        start13;
  logic [12:0] y13;
  logic [3:0]  s13;
  logic        b13, active13, done13;
  logic [1:0]  regime13;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_engine #(.W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .on(on), .start(start),
    .y(y), .s(s), .b(b), .active(active), .regime(regime), .done(done)
  );

  bit_engine #(.W(13)) dut13 (
    .clk(clk), .rst(rst), .x(x13), .on(on13), .start(start13),
    .y(y13), .s(s13), .b(b13), .active(active13), .regime(regime13), .done(done13)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a start on the 8-bit instance, then check every cycle up to the done cycle dc
  // plus one cycle after. poke re-asserts start with a different select during RUN.
  task automatic run8(input string tag, input logic [7:0] xv, input logic [1:0] ov,
                      input int dc, input logic [7:0] ey, input logic [3:0] es,
                      input logic eb, input bit poke);
    x = xv; on = ov; start = 1'b1;
    step();
    start = 1'b0; x = 8'h5A; on = ~ov;
    for (int c = 1; c <= dc; c++) begin
      if (c == 1) begin
        chk($sformatf("%s.c1_y", tag), 32'(y), 32'(xv));
        chk($sformatf("%s.c1_s", tag), 32'(s), 32'd0);
      end
      chk($sformatf("%s.active_c%0d", tag, c), 32'(active), 32'(c < dc));
      chk($sformatf("%s.done_c%0d", tag, c), 32'(done), 32'(c == dc));
      if (c == dc) begin
        chk($sformatf("%s.y", tag), 32'(y), 32'(ey));
        chk($sformatf("%s.s", tag), 32'(s), 32'(es));
        chk($sformatf("%s.b", tag), 32'(b), 32'(eb));
        chk($sformatf("%s.regime", tag), 32'(regime), 32'(ov));
      end
      if (poke && c == 2) begin start = 1'b1; on = ~ov; x = 8'hFF; end
      if (poke && c == 3) start = 1'b0;
      step();
    end
    chk($sformatf("%s.hold_done", tag), 32'(done), 32'd0);
    chk($sformatf("%s.hold_active", tag), 32'(active), 32'd0);
    chk($sformatf("%s.hold_y", tag), 32'(y), 32'(ey));
    chk($sformatf("%s.hold_s", tag), 32'(s), 32'(es));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; on = '0;
    start13 = 1'b0; x13 = '0; on13 = '0;
    step();
    step();
    chk("rst.y", 32'(y), 32'd0);
    chk("rst.s", 32'(s), 32'd0);
    chk("rst.b", 32'(b), 32'd0);
    chk("rst.active", 32'(active), 32'd0);
    chk("rst.regime", 32'(regime), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.y13", 32'(y13), 32'd0);
    rst = 1'b0;
    step();
    chk("idle.active", 32'(active), 32'd0);

    // popcount
    run8("pc_b5", 8'hB5, 2'b00, 10, 8'hB5, 4'd5, 1'b1, 1'b0);
    run8("pc_ff", 8'hFF, 2'b00, 10, 8'hFF, 4'd8, 1'b0, 1'b0);
    // leading-one normalise
    run8("lo_10", 8'h10, 2'b01, 5, 8'h80, 4'd3, 1'b0, 1'b0);
    run8("lo_00", 8'h00, 2'b01, 10, 8'h00, 4'd8, 1'b1, 1'b0);
    run8("lo_80", 8'h80, 2'b01, 2, 8'h80, 4'd0, 1'b0, 1'b0);
    // bit reverse, or popcount when the option is absent
`ifdef BIT_ENGINE_REVERSE_EN
    run8("rv_01", 8'h01, 2'b10, 10, 8'h80, 4'd8, 1'b0, 1'b0);
    run8("rv_81", 8'h81, 2'b10, 10, 8'h81, 4'd8, 1'b1, 1'b0);
`else
    run8("rv_01", 8'h01, 2'b10, 10, 8'h01, 4'd1, 1'b1, 1'b0);
    run8("rv_81", 8'h81, 2'b10, 10, 8'h81, 4'd2, 1'b0, 1'b0);
`endif
    // trailing-zero count, plain and with start/on disturbed mid-RUN
    run8("tz_28", 8'h28, 2'b11, 5, 8'h05, 4'd3, 1'b0, 1'b0);
    run8("tz_28p", 8'h28, 2'b11, 5, 8'h05, 4'd3, 1'b0, 1'b1);
    run8("tz_00", 8'h00, 2'b11, 10, 8'h00, 4'd8, 1'b1, 1'b0);

    // reset during RUN cycle 4
    x = 8'hB5; on = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mid.active_c4", 32'(active), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.y", 32'(y), 32'd0);
    chk("mid.s", 32'(s), 32'd0);
    chk("mid.b", 32'(b), 32'd0);
    chk("mid.active", 32'(active), 32'd0);
    chk("mid.regime", 32'(regime), 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("mid.no_done%0d", c), 32'(done), 32'd0);
      step();
    end
    run8("post_rst", 8'hB5, 2'b00, 10, 8'hB5, 4'd5, 1'b1, 1'b0);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; x = 8'h33; on = 2'b01;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start.active", 32'(active), 32'd0);
    chk("rst_start.y", 32'(y), 32'd0);
    chk("rst_start.regime", 32'(regime), 32'd0);
    step();

    // W=13, start held high: back-to-back runs, done every 15 cycles
    x13 = 13'h1FFF; on13 = 2'b00; start13 = 1'b1;
    step();
    for (int c = 1; c <= 45; c++) begin
      chk($sformatf("w13.active_c%0d", c), 32'(active13), 32'((c % 15) != 0));
      chk($sformatf("w13.done_c%0d", c), 32'(done13), 32'((c % 15) == 0));
      if ((c % 15) == 0) begin
        chk($sformatf("w13.s_c%0d", c), 32'(s13), 32'd13);
        chk($sformatf("w13.b_c%0d", c), 32'(b13), 32'd1);
        chk($sformatf("w13.y_c%0d", c), 32'(y13), 32'h1FFF);
      end
      step();
    end
    start13 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
